// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier register-access slice.
package mult_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    CAP  = 3'd3,
    RSP  = 3'd4
  } state_t;

endpackage

// File: rtl/reg_access_ctrl.sv
// Initiator for the single-port register interface: turns host write, read
// and write-then-verify requests into writeEnable/readEnable sequences and
// returns exactly one response per accepted request.
module reg_access_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned N = DATA_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic         req_verify,
  input  logic [N-1:0] req_wdata,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_rdata,
  output logic         rsp_mismatch,
  output logic         reg_we,
  output logic         reg_re,
  output logic [N-1:0] reg_din,
  input  logic [N-1:0] reg_dout,
  input  logic         reg_access_err,
  output logic         err_sticky
);

  state_t       state;
  state_t       state_next;
  logic         lat_verify;
  logic [N-1:0] lat_wdata;

  // State register; async reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and output decode; outputs depend on registered state/data only.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    reg_we     = 1'b0;
    reg_re     = 1'b0;
    reg_din    = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = req_write ? WR : RD;
      end
      WR: begin
        reg_we     = 1'b1;
        reg_din    = lat_wdata;
        state_next = lat_verify ? RD : RSP;
      end
      RD: begin
        reg_re     = 1'b1;
        state_next = CAP;
      end
      CAP: state_next = RSP;
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch and response holding registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_verify   <= 1'b0;
      lat_wdata    <= '0;
      rsp_rdata    <= '0;
      rsp_mismatch <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            // verify only has meaning for writes, so a read never flags a mismatch
            lat_verify <= req_write & req_verify;
            lat_wdata  <= req_wdata;
          end
        end
        WR: begin
          if (!lat_verify) begin
            rsp_rdata    <= '0;
            rsp_mismatch <= 1'b0;
          end
        end
        CAP: begin
          rsp_rdata    <= reg_dout;
          rsp_mismatch <= lat_verify && (reg_dout != lat_wdata);
        end
        default: ;
      endcase
    end
  end

  // Sticky record of any register access error; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               err_sticky <= 1'b0;
    else if (reg_access_err) err_sticky <= 1'b1;
  end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Directed bench for reg_access_ctrl with a behavioural single-port register
// as the responder.
module tb_reg_access_ctrl;

  localparam int unsigned N = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_write = 1'b0;
  logic         req_verify = 1'b0;
  logic [N-1:0] req_wdata = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [N-1:0] rsp_rdata;
  logic         rsp_mismatch;
  logic         reg_we;
  logic         reg_re;
  logic [N-1:0] reg_din;
  logic [N-1:0] reg_dout;
  logic         reg_access_err;
  logic         err_sticky;

  // Responder register: not cleared by the controller reset.
  logic [N-1:0] reg_q = '0;
  logic [N-1:0] reg_out = '0;
  logic         force_en = 1'b0;
  logic [N-1:0] force_val = '0;
  logic         err_inj = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;
  int we_cnt = 0;
  int re_cnt = 0;
  int both_cnt = 0;
  logic [N-1:0] last_din = '0;

  reg_access_ctrl #(.N(N)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_verify     (req_verify),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_mismatch   (rsp_mismatch),
    .reg_we         (reg_we),
    .reg_re         (reg_re),
    .reg_din        (reg_din),
    .reg_dout       (reg_dout),
    .reg_access_err (reg_access_err),
    .err_sticky     (err_sticky)
  );

  always #5 clk = ~clk;

  assign reg_dout       = force_en ? force_val : reg_out;
  assign reg_access_err = (reg_we & reg_re) | err_inj;

  // Single-port register: write on writeEnable, dataOut updates on readEnable.
  always @(posedge clk) begin
    if (reg_we) reg_q <= reg_din;
    if (reg_re) reg_out <= reg_q;
  end

  // Enable activity monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reg_we) begin
      we_cnt++;
      last_din = reg_din;
    end
    if (reg_re) re_cnt++;
    if (reg_we && reg_re) both_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One request with rsp_ready held high; lat counts edges from the accept edge (inclusive).
  task automatic do_req(input logic w, input logic v, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output logic mm);
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = w;
    req_verify = v;
    req_wdata  = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("rsp_valid_seen", rsp_valid, 1);
    rd = rsp_rdata;
    mm = rsp_mismatch;
    @(posedge clk);
    #1;
  endtask

  int          lat;
  logic [31:0] rd;
  logic        mm;
  int          we0, re0;
  logic [31:0] held;
  logic [31:0] model;
  logic        rw, rv;
  logic [31:0] rdat;
  int          wait_cnt;

  initial begin
    // Reset state
    #1;
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_rdata", rsp_rdata, 0);
    check_eq("rst_rsp_mismatch", rsp_mismatch, 0);
    check_eq("rst_reg_we", reg_we, 0);
    check_eq("rst_reg_re", reg_re, 0);
    check_eq("rst_reg_din", reg_din, 0);
    check_eq("rst_err_sticky", err_sticky, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst_req_ready", req_ready, 1);

    // 1: plain write
    we0 = we_cnt; re0 = re_cnt;
    do_req(1'b1, 1'b0, 32'hDEADBEEF, lat, rd, mm);
    check_eq("t1_we_cycles", we_cnt - we0, 1);
    check_eq("t1_re_cycles", re_cnt - re0, 0);
    check_eq("t1_reg_din", last_din, 32'hDEADBEEF);
    check_eq("t1_latency", lat, 2);
    check_eq("t1_rdata", rd, 0);
    check_eq("t1_mismatch", mm, 0);

    // 2: write then read
    do_req(1'b1, 1'b0, 32'h12345678, lat, rd, mm);
    we0 = we_cnt; re0 = re_cnt;
    do_req(1'b0, 1'b0, 32'h0, lat, rd, mm);
    check_eq("t2_latency", lat, 3);
    check_eq("t2_rdata", rd, 32'h12345678);
    check_eq("t2_re_cycles", re_cnt - re0, 1);
    check_eq("t2_we_cycles", we_cnt - we0, 0);
    check_eq("t2_mismatch", mm, 0);

    // 3: verify with corrupted readback, then clean
    force_val = 32'hA5A5A5A4;
    force_en  = 1'b1;
    do_req(1'b1, 1'b1, 32'hA5A5A5A5, lat, rd, mm);
    force_en  = 1'b0;
    check_eq("t3f_mismatch", mm, 1);
    check_eq("t3f_rdata", rd, 32'hA5A5A5A4);
    check_eq("t3f_latency", lat, 4);
    we0 = we_cnt; re0 = re_cnt;
    do_req(1'b1, 1'b1, 32'hA5A5A5A5, lat, rd, mm);
    check_eq("t3_mismatch", mm, 0);
    check_eq("t3_rdata", rd, 32'hA5A5A5A5);
    check_eq("t3_latency", lat, 4);
    check_eq("t3_we_cycles", we_cnt - we0, 1);
    check_eq("t3_re_cycles", re_cnt - re0, 1);

    // 4: response back-pressure with dropped requests
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_verify = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_cnt = 0;
    while (!rsp_valid && wait_cnt < 20) begin
      @(posedge clk);
      #1;
      wait_cnt++;
    end
    check_eq("t4_rsp_valid_seen", rsp_valid, 1);
    held = rsp_rdata;
    check_eq("t4_rdata", held, 32'hA5A5A5A5);
    we0 = we_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid  = (i % 2 == 0);
      req_write  = 1'b1;
      req_wdata  = 32'h0BADF00D;
      check_eq("t4_hold_valid", rsp_valid, 1);
      check_eq("t4_hold_rdata", rsp_rdata, held);
      check_eq("t4_req_ready_low", req_ready, 0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("t4_released_valid", rsp_valid, 0);
    check_eq("t4_released_ready", req_ready, 1);
    check_eq("t4_no_write", we_cnt - we0, 0);
    do_req(1'b0, 1'b0, 32'h0, lat, rd, mm);
    check_eq("t4_dropped_write", rd, 32'hA5A5A5A5);

    // Error flag is sticky
    @(negedge clk);
    err_inj = 1'b1;
    @(negedge clk);
    err_inj = 1'b0;
    check_eq("err_set", err_sticky, 1);
    @(negedge clk);
    @(negedge clk);
    check_eq("err_held", err_sticky, 1);

    // 5: reset during RD
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_verify = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_eq("t5_re_before", reg_re, 1);
    reset = 1'b1;
    #1;
    check_eq("t5_re_abort", reg_re, 0);
    check_eq("t5_valid_abort", rsp_valid, 0);
    check_eq("t5_err_cleared", err_sticky, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("t5_req_ready", req_ready, 1);
    check_eq("t5_err_after", err_sticky, 0);
    @(negedge clk);
    @(negedge clk);
    check_eq("t5_no_rsp", rsp_valid, 0);

    // 6: random mixed traffic against a register model
    model = 32'hA5A5A5A5;
    both_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      rw   = 1'($urandom_range(0, 1));
      rv   = 1'($urandom_range(0, 1));
      rdat = $urandom;
      do_req(rw, rv, rdat, lat, rd, mm);
      if (rw) begin
        if (rv) begin
          check_eq("t6_verify_rdata", rd, rdat);
          check_eq("t6_verify_lat", lat, 4);
        end else begin
          check_eq("t6_write_rdata", rd, 0);
          check_eq("t6_write_lat", lat, 2);
        end
        model = rdat;
      end else begin
        check_eq("t6_read_rdata", rd, model);
        check_eq("t6_read_lat", lat, 3);
      end
      check_eq("t6_mismatch", mm, 0);
    end
    check_eq("t6_we_re_exclusive", both_cnt, 0);
    check_eq("t6_err_sticky", err_sticky, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
